lfsr_scrambler: RTL
===================

# lfsr_scrambler

Parametrised AXI-Stream bit scrambler/descrambler, the successor to the fixed 7-bit 802.11 scrambler. LFSR length, feedback polynomial, seed, data width and sideband width are parameters. Mode is selectable: additive (frame-synchronous), multiplicative scramble, or multiplicative (self-synchronising) descramble. Runtime seed load and optional automatic reseed at frame end are supported. It sits in the transmit/receive bit pipeline between framing and coding stages, with one registered stage and full throughput.

## Interface
- WIDTH, 24, data bits per beat.
- LFSR_LEN, 7, shift-register length L (2..32).
- POLY, 7'b1001000, tap mask: POLY[k]=1 taps s[k] (default x^7+x^4+1).
- SEED, 7'b1011101, state after reset; must be non-zero in additive mode.
- USER_WIDTH, 4, tuser width.
- MODE, 0, 0=additive, 1=multiplicative scramble, 2=multiplicative descramble.
- RESEED_ON_LAST, 1, additive mode only: reload the seed after a beat with tlast.
- aclk  in  1  clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_seed  in  LFSR_LEN  runtime seed value.
- cfg_seed_load  in  1  single-cycle pulse that loads cfg_seed into the state and into the reseed register.
- s_axis_tdata  in  WIDTH  input data.
- s_axis_tuser  in  USER_WIDTH  sideband, passed through unchanged.
- s_axis_tlast  in  1  frame end, passed through unchanged.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  WIDTH  scrambled/descrambled data.
- m_axis_tuser  out  USER_WIDTH  delayed tuser.
- m_axis_tlast  out  1  delayed tlast.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

## Operation
- State s[L-1:0]. Bits within a beat are processed serially: tdata[0] first in time, tdata[WIDTH-1] last. The whole beat is computed combinationally in one cycle.
- Per-bit feedback: fb = ^(s & POLY).
- Additive mode:
  - y = x ^ fb.
  - s <= {s[L-2:0], fb}.
- Multiplicative scramble mode:
  - y = x ^ fb.
  - s <= {s[L-2:0], y}.
- Multiplicative descramble mode:
  - y = x ^ fb.
  - s <= {s[L-2:0], x}.
  - Self-synchronises after L input bits regardless of initial state.
- The state advances only on an accepted input beat (s_axis_tvalid & s_axis_tready), by exactly WIDTH bit-steps.
- Reseed register R holds SEED after reset and is overwritten by cfg_seed on cfg_seed_load.
- Reseed on tlast: when RESEED_ON_LAST=1, MODE=0, and the accepted beat has tlast=1, the next state is R instead of the advanced state.
- Seed load coinciding with an accepted beat: the beat is processed with the old state, and the next state is cfg_seed. Seed load has priority over reseed on tlast.
- tuser and tlast are captured alongside tdata and are never modified.

## Timing
- Latency: 1 cycle. A beat accepted at edge n appears on m_axis_* after edge n with m_axis_tvalid=1.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational). Full throughput of one beat per cycle when downstream is ready.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs are held stable and state does not advance.
- m_axis_tvalid falls after an edge where m_axis_tready=1 and no new beat is accepted.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, s=SEED, R=SEED. s_axis_tready is therefore 1 after reset.
- Reset mid-stream: an in-flight output beat is dropped and state returns to SEED immediately, asynchronously.
- cfg_seed_load takes effect at the edge where it is sampled, and is independent of handshakes.

## Structure
- Package lfsr_scrambler_pkg holds:
  - mode constants MODE_ADDITIVE=0, MODE_MULT_SCR=1, MODE_MULT_DESCR=2;
  - a function computing one bit-step for (state, in bit, mode, POLY).
- Sub-module lfsr_scrambler_core: purely combinational, unrolls WIDTH bit-steps and outputs the next state and the output word.
- The top level holds the state register, reseed register, output register and handshake logic.

## Test plan
- Additive sequence: WIDTH=8, default SEED/POLY, input 8'h00 → output 8'h36 (bit sequence 0,1,1,0,1,1,0,0); internal state then 7'b1101100. The next zero beat continues the sequence and matches a bit-serial software model.
- Frame reseed: send two beats, the first with tlast=1 and tuser=4'h3. The second beat's output equals the first beat's output for equal input; tuser 4'h3 and tlast are passed through.
- Round trip: chain MODE=1 into MODE=2 with differing seeds and send 10 random WIDTH=24 beats. All descrambled beats after the first ceil(L/WIDTH) beats equal the input.
- Backpressure: m_axis_tready low for 5 cycles with s_axis_tvalid high. Outputs are held, s_axis_tready=0, and the sequence resumes with no skipped or repeated bit-steps.
- Seed load: pulse cfg_seed_load with cfg_seed=7'b1011101 simultaneously with an accepted beat. That beat uses the old state, and the next zero beat outputs 8'h36.
- Reset mid-stream: assert areset with a beat pending. m_axis_tvalid drops to 0 asynchronously, and after release a zero beat yields 8'h36.

Source files
------------

// File: rtl/lfsr_scrambler_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_scrambler_pkg
// Shared definitions for the parametrised LFSR scrambler/descrambler.
//   - Mode encodings for the MODE parameter.
//   - parity32 : even-parity reduction used for the LFSR feedback.
//   - lfsr_step: one serial bit-step of the LFSR for any supported mode.
//                Works on a 32-bit container; only the low 'len' bits of the
//                state are meaningful and the upper bits are kept at zero.
// -----------------------------------------------------------------------------
package lfsr_scrambler_pkg;

   localparam int MODE_ADDITIVE   = 0;
   localparam int MODE_MULT_SCR   = 1;
   localparam int MODE_MULT_DESCR = 2;

   localparam int MAX_LFSR_LEN    = 32;

   // XOR reduction of a 32-bit vector (feedback parity).
   function automatic logic parity32(input logic [31:0] vec);
      return ^vec;
   endfunction

   // One bit-step. Returns {output_bit, next_state[31:0]}.
   // The shifted-in bit is the feedback itself (additive), the scrambled
   // output (multiplicative scramble) or the received bit (descramble), which
   // is what makes the descrambler self-synchronising.
   function automatic logic [32:0] lfsr_step(
      input logic [31:0] state,
      input logic        in_bit,
      input int          mode,
      input logic [31:0] poly,
      input int          len
   );
      logic        fb;
      logic        out_bit;
      logic        shift_in;
      logic [31:0] mask;
      logic [31:0] next_state;
      fb      = parity32(state & poly);
      out_bit = in_bit ^ fb;
      case (mode)
         MODE_MULT_SCR:   shift_in = out_bit;
         MODE_MULT_DESCR: shift_in = in_bit;
         default:         shift_in = fb;
      endcase
      // Keep bits at and above 'len' cleared so they never reach the taps.
      mask       = 32'hFFFF_FFFF >> (MAX_LFSR_LEN - len);
      next_state = {state[30:0], shift_in} & mask;
      return {out_bit, next_state};
   endfunction

endpackage : lfsr_scrambler_pkg

// File: rtl/lfsr_scrambler_core.sv
// -----------------------------------------------------------------------------
// lfsr_scrambler_core
// Purely combinational datapath: unrolls WIDTH serial LFSR bit-steps so one
// whole beat is scrambled/descrambled in a single cycle. data_in[0] is the
// first bit in time, data_in[WIDTH-1] the last.
// Ports:
//   state      in  LFSR_LEN  current LFSR state
//   data_in    in  WIDTH     input beat
//   next_state out LFSR_LEN  state after WIDTH bit-steps
//   data_out   out WIDTH     scrambled/descrambled beat
// -----------------------------------------------------------------------------
module lfsr_scrambler_core
   import lfsr_scrambler_pkg::*;
#(
   parameter int                  WIDTH    = 24,
   parameter int                  LFSR_LEN = 7,
   parameter logic [LFSR_LEN-1:0] POLY     = 7'b1001000,
   parameter int                  MODE     = MODE_ADDITIVE
) (
   input  logic [LFSR_LEN-1:0] state,
   input  logic [WIDTH-1:0]    data_in,
   output logic [LFSR_LEN-1:0] next_state,
   output logic [WIDTH-1:0]    data_out
);

   localparam logic [31:0] POLY_EXT = 32'(POLY);

   logic [31:0] walk_s;
   logic [32:0] step_s;

   // Unrolled bit-serial LFSR walk across the beat.
   always_comb begin
      walk_s   = 32'(state);
      step_s   = 33'd0;
      data_out = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         step_s      = lfsr_step(walk_s, data_in[i], MODE, POLY_EXT, LFSR_LEN);
         data_out[i] = step_s[32];
         walk_s      = step_s[31:0];
      end
      next_state = walk_s[LFSR_LEN-1:0];
   end

endmodule : lfsr_scrambler_core

// File: rtl/lfsr_scrambler.sv
// -----------------------------------------------------------------------------
// lfsr_scrambler
// AXI-Stream bit scrambler/descrambler with one registered output stage and
// full throughput. Holds the LFSR state, the reseed register, the output
// register and the ready/valid handshake.
// Ports:
//   aclk          in   clock, rising edge
//   areset        in   asynchronous active-high reset
//   cfg_seed      in   runtime seed
//   cfg_seed_load in   one-cycle pulse: load cfg_seed into state and reseed reg
//   s_axis_*      in   input stream (tdata/tuser/tlast/tvalid, tready out)
//   m_axis_*      out  output stream (tdata/tuser/tlast/tvalid, tready in)
// -----------------------------------------------------------------------------
module lfsr_scrambler
   import lfsr_scrambler_pkg::*;
#(
   parameter int                  WIDTH          = 24,
   parameter int                  LFSR_LEN       = 7,
   parameter logic [LFSR_LEN-1:0] POLY           = 7'b1001000,
   parameter logic [LFSR_LEN-1:0] SEED           = 7'b1011101,
   parameter int                  USER_WIDTH     = 4,
   parameter int                  MODE           = MODE_ADDITIVE,
   parameter bit                  RESEED_ON_LAST = 1'b1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [LFSR_LEN-1:0]   cfg_seed,
   input  logic                  cfg_seed_load,
   input  logic [WIDTH-1:0]      s_axis_tdata,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [WIDTH-1:0]      m_axis_tdata,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   // Reseeding on frame end only makes sense for the frame-synchronous mode.
   localparam bit RESEED_EN = RESEED_ON_LAST && (MODE == MODE_ADDITIVE);

   logic [LFSR_LEN-1:0]   state_r;
   logic [LFSR_LEN-1:0]   reseed_r;
   logic [WIDTH-1:0]      data_r;
   logic [USER_WIDTH-1:0] user_r;
   logic                  last_r;
   logic                  valid_r;

   logic                  ready_s;
   logic                  accept_s;
   logic [LFSR_LEN-1:0]   core_next_s;
   logic [WIDTH-1:0]      core_out_s;
   logic [LFSR_LEN-1:0]   state_nxt_s;

   lfsr_scrambler_core #(
      .WIDTH    (WIDTH),
      .LFSR_LEN (LFSR_LEN),
      .POLY     (POLY),
      .MODE     (MODE)
   ) u_core (
      .state      (state_r),
      .data_in    (s_axis_tdata),
      .next_state (core_next_s),
      .data_out   (core_out_s)
   );

   // Upstream may push whenever the output slot is empty or draining.
   assign ready_s  = ~valid_r | m_axis_tready;
   assign accept_s = s_axis_tvalid & ready_s;

   // Next LFSR state: seed load beats frame reseed, which beats advancing.
   always_comb begin
      if (cfg_seed_load) begin
         state_nxt_s = cfg_seed;
      end else if (accept_s) begin
         if (RESEED_EN && s_axis_tlast) begin
            state_nxt_s = reseed_r;
         end else begin
            state_nxt_s = core_next_s;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // LFSR state and reseed registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_r  <= SEED;
         reseed_r <= SEED;
      end else begin
         state_r <= state_nxt_s;
         if (cfg_seed_load) begin
            reseed_r <= cfg_seed;
         end else begin
            reseed_r <= reseed_r;
         end
      end
   end

   // Output register stage; payload is held while the slot is stalled.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         valid_r <= 1'b0;
         data_r  <= {WIDTH{1'b0}};
         user_r  <= {USER_WIDTH{1'b0}};
         last_r  <= 1'b0;
      end else if (accept_s) begin
         valid_r <= 1'b1;
         data_r  <= core_out_s;
         user_r  <= s_axis_tuser;
         last_r  <= s_axis_tlast;
      end else if (m_axis_tready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign s_axis_tready = ready_s;
   assign m_axis_tdata  = data_r;
   assign m_axis_tuser  = user_r;
   assign m_axis_tlast  = last_r;
   assign m_axis_tvalid = valid_r;

endmodule : lfsr_scrambler
